// File: rtl/bist_response_checker.sv
// Clocked BIST response checker: masked magnitude compare per read-back beat,
// with run statistics (saturating fail count, first-fail capture) and done/pass handshake.
module bist_response_checker #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              cmp_valid,
  input  logic              cmp_last,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_t,
  input  logic [DATA_W-1:0] ramout,
  input  logic [DATA_W-1:0] mask,
  output logic              res_valid,
  output logic              gt,
  output logic              eq,
  output logic              lt,
  output logic              fail,
  output logic [CNT_W-1:0]  fail_count,
  output logic [ADDR_W-1:0] ff_addr,
  output logic [DATA_W-1:0] ff_exp,
  output logic [DATA_W-1:0] ff_act,
  output logic              busy,
  output logic              done,
  output logic              pass
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state;

  logic [DATA_W-1:0] e_masked;
  logic [DATA_W-1:0] a_masked;
  logic              accept;
  logic              mismatch;

  // Saturating increment: the counter sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    logic [CNT_W-1:0] one;
    one = {{(CNT_W-1){1'b0}}, 1'b1};
    if (c == {CNT_W{1'b1}}) sat_inc = c;
    else                    sat_inc = c + one;
  endfunction

  assign e_masked = data_t & ~mask;
  assign a_masked = ramout & ~mask;
  assign accept   = (state == RUN) && cmp_valid && !start;
  assign mismatch = (e_masked != a_masked);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      res_valid  <= 1'b0;
      gt         <= 1'b0;
      eq         <= 1'b0;
      lt         <= 1'b0;
      fail       <= 1'b0;
      fail_count <= '0;
      ff_addr    <= '0;
      ff_exp     <= '0;
      ff_act     <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
    end else if (start) begin
      // start wins over any beat presented in the same cycle
      state      <= RUN;
      res_valid  <= 1'b0;
      gt         <= 1'b0;
      eq         <= 1'b0;
      lt         <= 1'b0;
      fail       <= 1'b0;
      fail_count <= '0;
      ff_addr    <= '0;
      ff_exp     <= '0;
      ff_act     <= '0;
      busy       <= 1'b1;
      done       <= 1'b0;
      pass       <= 1'b0;
    end else begin
      res_valid <= accept;
      if (accept) begin
        gt <= (e_masked >  a_masked);
        eq <= (e_masked == a_masked);
        lt <= (e_masked <  a_masked);
        if (mismatch) begin
          fail       <= 1'b1;
          fail_count <= sat_inc(fail_count);
          if (!fail) begin
            ff_addr <= addr;
            ff_exp  <= data_t;
            ff_act  <= ramout;
          end
        end
        if (cmp_last) begin
          // pass already folds in the verdict of this final beat
          state <= DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
          pass  <= !(fail || mismatch);
        end
      end
    end
  end

endmodule

// File: doc/bist_response_checker.md
# bist_response_checker

Clocked, parametrised successor to the combinational BIST data comparator. It sits between the March-test sequencer and the BIST status registers. For each read-back beat it compares expected data against RAM output under a bit mask and reports registered gt/eq/lt flags. Across a test run it accumulates a saturating failure count, captures the first failing address and data, and returns a done/pass handshake to the sequencer.

## Interface
- DATA_W, 8, width of expected/actual data and mask
- ADDR_W, 8, width of address tag
- CNT_W, 8, width of failure counter
- clk  input  1  single clock, rising-edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  one-cycle pulse; clears statistics and begins a run
- cmp_valid  input  1  compare beat valid this cycle
- cmp_last  input  1  qualifies cmp_valid; final beat of the run
- addr  input  ADDR_W  address of the beat
- data_t  input  DATA_W  expected data
- ramout  input  DATA_W  actual data from memory
- mask  input  DATA_W  1 = bit ignored in compare
- res_valid  output  1  registered compare result valid
- gt  output  1  masked data_t > masked ramout
- eq  output  1  masked data_t == masked ramout
- lt  output  1  masked data_t < masked ramout
- fail  output  1  sticky; any mismatch this run
- fail_count  output  CNT_W  mismatches this run, saturating
- ff_addr  output  ADDR_W  address of first mismatch
- ff_exp  output  DATA_W  expected data of first mismatch
- ff_act  output  DATA_W  actual data of first mismatch
- busy  output  1  state == RUN
- done  output  1  state == DONE
- pass  output  1  done && !fail

## Operation
- States: IDLE, RUN, DONE.
  - IDLE: start -> RUN.
  - RUN: accepted beat with cmp_last -> DONE.
  - DONE: start -> RUN. Otherwise hold.
- start in any state clears fail, fail_count, ff_addr, ff_exp, ff_act, gt, eq, lt and res_valid to 0, and enters RUN.
- start in RUN restarts the run. start has priority over a simultaneous cmp_valid, and that beat is discarded.
- A beat is accepted only when the state is RUN, cmp_valid=1 and start=0. cmp_valid in IDLE or DONE is ignored, and all outputs hold.
- Masked operands: e = data_t & ~mask, a = ramout & ~mask. Both are unsigned DATA_W-bit values.
- Exactly one of gt/eq/lt is 1 whenever res_valid=1. The flags hold their last value when res_valid=0.
- Mismatch means an accepted beat with e != a. All-ones mask therefore always gives eq=1.
- On mismatch:
  - fail_count increments, saturating at 2^CNT_W-1 with no wrap.
  - fail sets.
  - If fail was 0, ff_addr/ff_exp/ff_act capture addr, data_t and ramout (unmasked raw values). Later mismatches do not overwrite them.
- Statistics persist through DONE until the next start or rst.

## Timing
- rst asserted: immediately state=IDLE and every output 0 (pass=0), independent of clk. This also applies mid-run, and the run is lost.
- Beat accepted at edge N:
  - res_valid=1 and gt/eq/lt are visible after edge N, for one cycle per beat.
  - fail_count, fail and ff_* update at the same edge N.
- Back-to-back beats every cycle are supported with no stall. res_valid follows cmp_valid with 1-cycle latency.
- Beat with cmp_last accepted at edge N: done=1 and busy=0 after edge N. pass is valid in the same cycle, and the last beat's result and count are already included.
- start at edge N: busy=1 after edge N, and statistics read 0 in that cycle.
- Counter saturation and a first-fail capture on the same beat are both handled at one edge.

## Test plan
- Clean run: start, 16 beats with data_t=ramout=0xA5 and mask=0x00, last on beat 16. Required: eq=1 on each res_valid, fail_count=0, done=1 and pass=1 one cycle after the last beat.
- Compare ordering: data_t=0x80 vs ramout=0x7F gives gt=1. 0x01 vs 0x02 gives lt=1. With mask=0x80, 0x80 vs 0x00 gives eq=1 and no count.
- First-fail capture: mismatches at addr 0x05 (exp 0x55, act 0x54) and 0x09. Required: ff_addr=0x05, ff_exp=0x55, ff_act=0x54, fail_count=2, pass=0 at done.
- Saturation: CNT_W=2 with 6 mismatches. Required: fail_count=3 and stays 3.
- Priority and ignore: start together with a mismatching cmp_valid in RUN gives fail_count=0 and res_valid=0. cmp_valid in IDLE gives no res_valid.
- Async reset mid-run: rst asserted between clock edges after 3 mismatches. Required: all outputs 0 before the next edge and state IDLE. After rst deasserts, start begins a clean run.
